// File: rtl/cache_nway_wb_if.sv
// Processor and memory bus of the N-way write-back cache.
// The cache takes the slave view; the processor/memory side takes the master view.
interface cache_nway_wb_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement (invalid ways preferred) and free-running hit/miss counters.
module cache_nway_wb #(
    parameter int WAYS      = 4,
    parameter int WAY_W     = 2,
    parameter int SET_IDX_W = 2,
    parameter int ADDR_W    = 30,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    cache_nway_wb_if.slave   bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int SETS   = 1 << SET_IDX_W;
    localparam int TAG_W  = ADDR_W - SET_IDX_W - 2;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

    state_t state;

    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic [WAY_W-1:0]  age_q   [WAYS][SETS];
    logic [WAY_W-1:0]  victim_q;

    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-3:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q;

    logic [TAG_W-1:0]     tag;
    logic [SET_IDX_W-1:0] set_idx;
    logic [1:0]           offset;
    logic                 req;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic                 vic_found;
    logic [WAY_W-1:0]     victim_way;
    logic [31:0]          hit_word;

    assign tag     = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign set_idx = bus.proc_addr[SET_IDX_W+1:2];
    assign offset  = bus.proc_addr[1:0];
    assign req     = bus.proc_read ^ bus.proc_write;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        vic_found  = 1'b0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][set_idx] && tag_q[w][set_idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[w][set_idx]) begin
                vic_found  = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[w][set_idx] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[hit_way][set_idx][{offset, 5'd0} +: 32];

    assign bus.proc_stall = !proc_reset && ((state != IDLE) || (req && !hit));
    assign bus.proc_rdata = (!proc_reset && state == IDLE && req && bus.proc_read && hit)
                            ? hit_word : 32'h0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // NOTE: line data and tags carry no reset; valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (state == IDLE && req && hit && bus.proc_write)
            data_q[hit_way][set_idx][{offset, 5'd0} +: 32] <= bus.proc_wdata;
        if (state == ALLOCATE && bus.mem_ready) begin
            data_q[victim_q][set_idx] <= bus.mem_rdata;
            tag_q[victim_q][set_idx]  <= tag;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state       <= IDLE;
            victim_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        hit_count <= hit_count + 1'b1;
                        if (bus.proc_write) dirty_q[hit_way][set_idx] <= 1'b1;
                        // Hit way becomes youngest; only ways younger than it age by one.
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_q[w][set_idx] <= '0;
                            else if (age_q[w][set_idx] < age_q[hit_way][set_idx])
                                age_q[w][set_idx] <= age_q[w][set_idx] + 1'b1;
                        end
                    end else if (req) begin
                        miss_count <= miss_count + 1'b1;
                        victim_q   <= victim_way;
                        if (valid_q[victim_way][set_idx] && dirty_q[victim_way][set_idx]) begin
                            state       <= WRITE_BACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[victim_way][set_idx], set_idx};
                            mem_wdata_q <= data_q[victim_way][set_idx];
                        end else begin
                            state      <= ALLOCATE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {tag, set_idx};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_ready) begin
                        dirty_q[victim_q][set_idx] <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= {tag, set_idx};
                        state       <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        valid_q[victim_q][set_idx] <= 1'b1;
                        dirty_q[victim_q][set_idx] <= 1'b0;
                        mem_read_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: a flat word-memory model gives expected read data,
// a line-memory responder serves fills and checks write-backs.
module tb_cache_nway_wb;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             proc_reset;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    cache_nway_wb_if #(.ADDR_W(30)) bus ();

    cache_nway_wb #(
        .WAYS(4), .WAY_W(2), .SET_IDX_W(2), .ADDR_W(30), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0]  gold  [logic [29:0]];
    logic [127:0] mem_q [logic [27:0]];
    logic [31:0]  sb_q  [$];
    logic [CNT_W-1:0] m_hit  = '0;
    logic [CNT_W-1:0] m_miss = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [27:0] la);
        logic [127:0] l;
        if (la == 28'h4) return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = {2'b11, la, 2'(k)};
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        return mem_q.exists(la) ? mem_q[la] : pattern(la);
    endfunction

    function automatic logic [31:0] gold_word(input logic [29:0] a);
        logic [127:0] l;
        if (gold.exists(a)) return gold[a];
        l = mem_line(a[29:2]);
        return l[32*int'(a[1:0]) +: 32];
    endfunction

    function automatic logic [127:0] gold_line(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = gold_word({la, 2'(k)});
        return l;
    endfunction

    function automatic logic [29:0] mk(input int t, input int s, input int o);
        return 30'((t << 4) | (s << 2) | o);
    endfunction

    function automatic logic [27:0] ln(input int t, input int s);
        return 28'((t << 2) | s);
    endfunction

    // One processor access, including any write-back/fill it triggers and its replay.
    task automatic access(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                          input bit exp_miss, input bit exp_wb, input logic [27:0] wb_addr);
        bit saw_wb = 0, saw_fill = 0, after_wb = 0;
        int cyc = 0, wait_n = 0;
        logic [27:0]  hold_addr;
        logic [127:0] hold_data;
        @(negedge clk);
        bus.proc_read  = !wr;
        bus.proc_write = wr;
        bus.proc_addr  = addr;
        bus.proc_wdata = wd;
        sb_q.push_back(wr ? 32'h0 : gold_word(addr));
        if (wr) gold[addr] = wd;
        if (exp_miss) m_miss++;
        m_hit++;
        #1;
        check("miss_stall", bus.proc_stall, exp_miss);
        while (bus.proc_stall && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            check("mem_excl", bus.mem_read & bus.mem_write, 1'b0);
            if (after_wb) begin
                check("wb_then_fill", bus.mem_read, 1'b1);
                after_wb = 0;
            end
            if (bus.mem_write) begin
                if (!saw_wb) begin
                    saw_wb    = 1;
                    wait_n    = 0;
                    hold_addr = bus.mem_addr;
                    hold_data = bus.mem_wdata;
                    check("wb_addr", bus.mem_addr, wb_addr);
                    check("wb_line", bus.mem_wdata, gold_line(bus.mem_addr));
                end
                wait_n++;
                if (wait_n == 3) begin
                    check("wb_hold", {bus.mem_addr, bus.mem_wdata}, {hold_addr, hold_data});
                    mem_q[bus.mem_addr] = bus.mem_wdata;
                    bus.mem_ready = 1'b1;
                    after_wb = 1;
                end
            end else if (bus.mem_read) begin
                if (!saw_fill) begin
                    saw_fill = 1;
                    wait_n   = 0;
                    check("fill_addr", bus.mem_addr, addr[29:2]);
                end
                wait_n++;
                if (wait_n == 2) begin
                    bus.mem_rdata = mem_line(bus.mem_addr);
                    bus.mem_ready = 1'b1;
                end
            end
        end
        check("timeout", bus.proc_stall, 1'b0);
        check("wb_seen", saw_wb, exp_wb);
        check("fill_seen", saw_fill, exp_miss);
        check("rdata", bus.proc_rdata, sb_q.pop_front());
        @(posedge clk);
        #1;
        check("hit_count", hit_count, m_hit);
        check("miss_count", miss_count, m_miss);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h10;
        bus.proc_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        proc_reset     = 1'b1;

        // Reset state, with a pending read present during reset.
        #12;
        check("rst_stall", bus.proc_stall, 1'b0);
        check("rst_rdata", bus.proc_rdata, 32'h0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 28'h0);
        check("rst_mem_wdata", bus.mem_wdata, 128'h0);
        check("rst_hits", hit_count, 4'd0);
        check("rst_misses", miss_count, 4'd0);
        bus.proc_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;

        // Cold read miss, then write hit in the same line.
        access(0, 30'h10, 32'h0, 1, 0, '0);
        access(1, 30'h11, 32'h0000_DEAD, 0, 0, '0);

        // Fill set 0; the next tag evicts the dirty LRU line 0x4.
        access(0, mk(2, 0, 0), 32'h0, 1, 0, '0);
        access(0, mk(3, 0, 0), 32'h0, 1, 0, '0);
        access(0, mk(4, 0, 0), 32'h0, 1, 0, '0);
        access(0, mk(5, 0, 0), 32'h0, 1, 1, 28'h4);
        access(0, 30'h11, 32'h0, 1, 0, '0);

        // Invalid-way preference in set 1: third tag must not evict the dirty lines.
        access(1, mk(1, 1, 2), 32'hA1A1_0001, 1, 0, '0);
        access(1, mk(2, 1, 3), 32'hA2A2_0002, 1, 0, '0);
        access(0, mk(3, 1, 0), 32'h0, 1, 0, '0);
        access(0, mk(1, 1, 2), 32'h0, 0, 0, '0);
        access(0, mk(2, 1, 3), 32'h0, 0, 0, '0);

        // LRU order in set 2: dirty lines make the victim visible on the write-back address.
        for (int t = 1; t <= 4; t++) access(1, mk(t, 2, 1), 32'hB000_0000 + t, 1, 0, '0);
        for (int t = 1; t <= 3; t++) access(0, mk(t, 2, 1), 32'h0, 0, 0, '0);
        access(0, mk(5, 2, 0), 32'h0, 1, 1, ln(4, 2));
        access(0, mk(5, 2, 2), 32'h0, 0, 0, '0);
        access(0, mk(6, 2, 0), 32'h0, 1, 1, ln(1, 2));

        // Reset asserted mid-ALLOCATE with mem_ready low.
        @(negedge clk);
        bus.proc_read = 1'b1;
        bus.proc_addr = mk(7, 3, 0);
        for (int i = 0; i < 10 && !bus.mem_read; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_fill", bus.mem_read, 1'b1);
        #1;
        proc_reset = 1'b1;
        #1;
        check("mid_rst_mem_read", bus.mem_read, 1'b0);
        check("mid_rst_stall", bus.proc_stall, 1'b0);
        check("mid_rst_hits", hit_count, 4'd0);
        check("mid_rst_misses", miss_count, 4'd0);
        bus.proc_read = 1'b0;
        m_hit  = '0;
        m_miss = '0;
        gold.delete();
        @(negedge clk);
        proc_reset = 1'b0;
        access(0, mk(7, 3, 0), 32'h0, 1, 0, '0);
        access(0, 30'h11, 32'h0, 1, 0, '0);

        // Both request lines asserted: no request at all.
        @(negedge clk);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b1;
        bus.proc_addr  = mk(9, 1, 0);
        #1;
        check("both_stall", bus.proc_stall, 1'b0);
        @(negedge clk);
        bus.proc_addr = 30'h11;
        #1;
        check("both_rdata", bus.proc_rdata, 32'h0);
        @(posedge clk);
        #1;
        check("both_mem_read", bus.mem_read, 1'b0);
        check("both_hits", hit_count, m_hit);
        check("both_misses", miss_count, m_miss);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;

        // Counter wrap at CNT_W=4: 17 hits from reset.
        @(negedge clk);
        proc_reset = 1'b1;
        @(negedge clk);
        proc_reset = 1'b0;
        m_hit  = '0;
        m_miss = '0;
        gold.delete();
        access(0, 30'h10, 32'h0, 1, 0, '0);
        for (int i = 0; i < 16; i++) access(0, 30'h10 + 30'(i % 4), 32'h0, 0, 0, '0);
        check("hit_wrap", hit_count, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
